// File: rtl/cpu_pkg.sv
// Shared types for the cpu_seq sequencer: opcodes, FSM states, instruction field positions.
// Consumed by cpu_decode and cpu_seq.
package cpu_pkg;

  typedef enum logic [3:0] {
    OPC_NOP  = 4'h0,
    OPC_ADD  = 4'h1,
    OPC_LDI  = 4'h2,
    OPC_JMP  = 4'h3,
    OPC_JZ   = 4'h4,
    OPC_JNZ  = 4'h5,
    OPC_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 8;
  localparam int RS2_MSB = 7;
  localparam int RS2_LSB = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Opcodes 6..E have no defined behaviour.
  function automatic logic opc_illegal(input logic [3:0] opc);
    return (opc >= 4'h6) && (opc <= 4'hE);
  endfunction

endpackage

// File: rtl/cpu_decode.sv
// Purely combinational instruction decoder: splits a 16-bit instruction into
// register fields, imm8 and one-hot opcode class flags.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [15:0] instr,
  output logic [1:0]  rd,
  output logic [1:0]  rs1,
  output logic [1:0]  rs2,
  output logic [7:0]  imm8,
  output logic        is_add,
  output logic        is_ldi,
  output logic        is_jmp,
  output logic        is_jz,
  output logic        is_jnz,
  output logic        is_halt,
  output logic        is_illegal
);

  logic [3:0] opc_s;

  // field extraction and opcode classification
  always_comb begin
    opc_s      = instr[OPC_MSB:OPC_LSB];
    rd         = instr[RD_MSB:RD_LSB];
    rs1        = instr[RS1_MSB:RS1_LSB];
    rs2        = instr[RS2_MSB:RS2_LSB];
    imm8       = instr[IMM_MSB:IMM_LSB];
    is_add     = 1'b0;
    is_ldi     = 1'b0;
    is_jmp     = 1'b0;
    is_jz      = 1'b0;
    is_jnz     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opc_s)
      OPC_ADD:  is_add  = 1'b1;
      OPC_LDI:  is_ldi  = 1'b1;
      OPC_JMP:  is_jmp  = 1'b1;
      OPC_JZ:   is_jz   = 1'b1;
      OPC_JNZ:  is_jnz  = 1'b1;
      OPC_HALT: is_halt = 1'b1;
      default:  is_illegal = opc_illegal(opc_s);
    endcase
  end

endmodule

// File: rtl/cpu_seq.sv
// Fetch/decode/issue sequencer for the 16-bit ADD-only datapath, one instruction in flight.
// Optional macro CPU_SEQ_ILLEGAL_TRAP_EN: illegal opcodes halt the core and raise a sticky illegal_o.
module cpu_seq
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int                REG_AW   = 2
) (
  input  logic              clk,
  input  logic              reset_n_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_valid_i,
  input  logic [15:0]       imem_data_i,
  output logic [REG_AW-1:0] rf_raddr1_o,
  output logic [REG_AW-1:0] rf_raddr2_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic              rf_we_o,
  output logic              rf_wsel_o,
  output logic [15:0]       imm_o,
  output logic              alu_op_o,
  input  logic              z_flag_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted_o,
  output logic              illegal_o
);

`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  state_e            state_r, state_nx;
  logic [ADDR_W-1:0] pc_r, pc_nx, pc_inc_s, target_s;
  logic [15:0]       ir_r, ir_nx;
  logic              imem_req_s;

  logic [1:0] dec_rd, dec_rs1, dec_rs2;
  logic [7:0] dec_imm8;
  logic       dec_add, dec_ldi, dec_jmp, dec_jz, dec_jnz, dec_halt, dec_illegal;

  cpu_decode u_decode (
    .instr      (ir_r),
    .rd         (dec_rd),
    .rs1        (dec_rs1),
    .rs2        (dec_rs2),
    .imm8       (dec_imm8),
    .is_add     (dec_add),
    .is_ldi     (dec_ldi),
    .is_jmp     (dec_jmp),
    .is_jz      (dec_jz),
    .is_jnz     (dec_jnz),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal)
  );

  assign pc_inc_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign target_s = ADDR_W'(dec_imm8);

  // state, PC and instruction register
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= ST_FETCH;
      pc_r    <= RESET_PC;
      ir_r    <= 16'h0000;
    end else begin
      state_r <= state_nx;
      pc_r    <= pc_nx;
      ir_r    <= ir_nx;
    end
  end

  // next-state, next-PC and per-state control strobes
  always_comb begin
    state_nx    = state_r;
    pc_nx       = pc_r;
    ir_nx       = ir_r;
    imem_req_s  = 1'b0;
    rf_raddr1_o = {REG_AW{1'b0}};
    rf_raddr2_o = {REG_AW{1'b0}};
    rf_waddr_o  = {REG_AW{1'b0}};
    rf_we_o     = 1'b0;
    rf_wsel_o   = 1'b0;
    imm_o       = 16'h0000;
    alu_op_o    = 1'b0;
    case (state_r)
      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (imem_valid_i) begin
          ir_nx    = imem_data_i;
          state_nx = ST_EXEC;
        end else begin
          ir_nx    = ir_r;
          state_nx = ST_FETCH;
        end
      end
      ST_EXEC: begin
        state_nx = ST_FETCH;
        pc_nx    = pc_inc_s;
        if (dec_add) begin
          alu_op_o    = 1'b1;
          rf_raddr1_o = REG_AW'(dec_rs1);
          rf_raddr2_o = REG_AW'(dec_rs2);
          rf_waddr_o  = REG_AW'(dec_rd);
          rf_we_o     = 1'b1;
        end else if (dec_ldi) begin
          rf_waddr_o = REG_AW'(dec_rd);
          rf_we_o    = 1'b1;
          rf_wsel_o  = 1'b1;
          imm_o      = {8'h00, dec_imm8};
        end else if (dec_jmp) begin
          pc_nx = target_s;
        end else if (dec_jz) begin
          pc_nx = z_flag_i ? target_s : pc_inc_s;
        end else if (dec_jnz) begin
          pc_nx = z_flag_i ? pc_inc_s : target_s;
        end else if (dec_halt || (dec_illegal && TRAP_EN)) begin
          // PC stays on the halting / offending instruction
          state_nx = ST_HALT;
          pc_nx    = pc_r;
        end else begin
          pc_nx = pc_inc_s;
        end
      end
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_FETCH;
    endcase
  end

  // request is gated by reset so it drops the instant reset asserts
  assign imem_req_o  = imem_req_s & reset_n_i;
  assign imem_addr_o = pc_r;
  assign pc_o        = pc_r;
  assign halted_o    = (state_r == ST_HALT);

`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
  logic illegal_r;

  // sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      illegal_r <= 1'b0;
    end else if ((state_r == ST_EXEC) && dec_illegal) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  assign illegal_o = illegal_r;
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_seq.sv
// Self-checking bench for cpu_seq: behaves as instruction memory, register file and ALU,
// and compares every cycle against an instruction-level reference interpreter.
module tb_cpu_seq;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        imem_req_o;
  logic [7:0]  imem_addr_o;
  logic        imem_valid_i;
  logic [15:0] imem_data_i;
  logic [1:0]  rf_raddr1_o, rf_raddr2_o, rf_waddr_o;
  logic        rf_we_o, rf_wsel_o;
  logic [15:0] imm_o;
  logic        alu_op_o;
  logic        z_flag_i;
  logic [7:0]  pc_o;
  logic        halted_o;
  logic        illegal_o;

  always #5 clk = ~clk;

  cpu_seq #(.ADDR_W(8), .RESET_PC(8'h00), .REG_AW(2)) dut (
    .clk          (clk),
    .reset_n_i    (reset_n_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_valid_i (imem_valid_i),
    .imem_data_i  (imem_data_i),
    .rf_raddr1_o  (rf_raddr1_o),
    .rf_raddr2_o  (rf_raddr2_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_we_o      (rf_we_o),
    .rf_wsel_o    (rf_wsel_o),
    .imm_o        (imm_o),
    .alu_op_o     (alu_op_o),
    .z_flag_i     (z_flag_i),
    .pc_o         (pc_o),
    .halted_o     (halted_o),
    .illegal_o    (illegal_o)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [0:255];
  logic [15:0] env_rf [0:3];
  logic [15:0] m_rf [0:3];
  logic        env_z, m_z;
  logic [7:0]  m_pc;
  logic        m_halted, m_illegal, exp_exec, fetch_active;
  int          wait_left;
  logic [15:0] cur_instr;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic restart_model();
    m_pc         = 8'h00;
    m_halted     = 1'b0;
    m_illegal    = 1'b0;
    exp_exec     = 1'b0;
    fetch_active = 1'b0;
    wait_left    = 0;
  endtask

  task automatic init_regs();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 16'($urandom);
      env_rf[i] = v;
      m_rf[i]   = v;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n_i    = 1'b0;
    imem_valid_i = 1'b0;
    #1;
    check_eq("rst_req", 32'(imem_req_o), 32'd0);
    check_eq("rst_pc", 32'(pc_o), 32'h00);
    check_eq("rst_addr", 32'(imem_addr_o), 32'h00);
    check_eq("rst_we", 32'(rf_we_o), 32'd0);
    check_eq("rst_alu", 32'(alu_op_o), 32'd0);
    check_eq("rst_imm", 32'(imm_o), 32'd0);
    check_eq("rst_halted", 32'(halted_o), 32'd0);
    check_eq("rst_illegal", 32'(illegal_o), 32'd0);
    repeat (2) @(negedge clk);
    reset_n_i = 1'b1;
    restart_model();
  endtask

  // Reference interpreter for one instruction; also plays register file / ALU from DUT controls.
  task automatic exec_step();
    logic [3:0]  opc;
    logic [1:0]  rd, rs1, rs2;
    logic [7:0]  imm, nxt;
    logic [15:0] sum, msum;
    opc = cur_instr[15:12];
    rd  = cur_instr[11:10];
    rs1 = cur_instr[9:8];
    rs2 = cur_instr[7:6];
    imm = cur_instr[7:0];
    check_eq("ex_pc", 32'(pc_o), 32'(m_pc));
    check_eq("ex_req", 32'(imem_req_o), 32'd0);
    check_eq("ex_alu_op", 32'(alu_op_o), 32'(opc == 4'h1));
    check_eq("ex_we", 32'(rf_we_o), 32'((opc == 4'h1) || (opc == 4'h2)));
    if (opc == 4'h1) begin
      check_eq("add_ra1", 32'(rf_raddr1_o), 32'(rs1));
      check_eq("add_ra2", 32'(rf_raddr2_o), 32'(rs2));
      check_eq("add_wa", 32'(rf_waddr_o), 32'(rd));
      check_eq("add_wsel", 32'(rf_wsel_o), 32'd0);
    end
    if (opc == 4'h2) begin
      check_eq("ldi_wa", 32'(rf_waddr_o), 32'(rd));
      check_eq("ldi_wsel", 32'(rf_wsel_o), 32'd1);
      check_eq("ldi_imm", 32'(imm_o), 32'({8'h00, imm}));
    end
    sum = env_rf[rf_raddr1_o] + env_rf[rf_raddr2_o];
    if (rf_we_o) env_rf[rf_waddr_o] = rf_wsel_o ? imm_o : sum;
    if (alu_op_o) env_z = (sum == 16'h0000);
    nxt = m_pc + 8'd1;
    case (opc)
      4'h0: m_pc = nxt;
      4'h1: begin
        msum     = m_rf[rs1] + m_rf[rs2];
        m_rf[rd] = msum;
        m_z      = (msum == 16'h0000);
        m_pc     = nxt;
      end
      4'h2: begin
        m_rf[rd] = {8'h00, imm};
        m_pc     = nxt;
      end
      4'h3: m_pc = imm;
      4'h4: m_pc = m_z ? imm : nxt;
      4'h5: m_pc = m_z ? nxt : imm;
      4'hF: m_halted = 1'b1;
      default: begin
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        m_halted  = 1'b1;
        m_illegal = 1'b1;
`else
        m_pc = nxt;
`endif
      end
    endcase
  endtask

  // dly < 0: random 0..3 wait cycles per fetch; otherwise a fixed wait.
  task automatic run_prog(input int max_instr, input int dly);
    int   cyc, ninstr, hcyc, last_acc;
    logic acc;
    cyc = 0; ninstr = 0; hcyc = 0; last_acc = -1;
    while (cyc < 3000 && hcyc < 20 && ninstr < max_instr) begin
      @(negedge clk);
      cyc++;
      acc = 1'b0;
      check_eq("halted", 32'(halted_o), 32'(m_halted));
      check_eq("illegal", 32'(illegal_o), 32'(m_illegal));
      if (exp_exec) begin
        imem_valid_i = 1'($urandom_range(0, 1));
        exec_step();
        exp_exec = 1'b0;
        ninstr++;
      end else if (m_halted) begin
        imem_valid_i = 1'($urandom_range(0, 1));
        check_eq("halt_req", 32'(imem_req_o), 32'd0);
        check_eq("halt_we", 32'(rf_we_o), 32'd0);
        check_eq("halt_alu", 32'(alu_op_o), 32'd0);
        check_eq("halt_pc", 32'(pc_o), 32'(m_pc));
        hcyc++;
      end else begin
        check_eq("f_req", 32'(imem_req_o), 32'd1);
        check_eq("f_addr", 32'(imem_addr_o), 32'(m_pc));
        check_eq("f_pc", 32'(pc_o), 32'(m_pc));
        check_eq("f_we", 32'(rf_we_o), 32'd0);
        check_eq("f_alu", 32'(alu_op_o), 32'd0);
        if (!fetch_active) begin
          fetch_active = 1'b1;
          wait_left    = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
        end
        if (wait_left == 0) begin
          imem_valid_i = 1'b1;
          imem_data_i  = mem[imem_addr_o];
          cur_instr    = mem[m_pc];
          fetch_active = 1'b0;
          acc          = 1'b1;
          if (dly >= 0 && last_acc >= 0) check_eq("cpi", 32'(cyc - last_acc), 32'(dly + 2));
          last_acc = cyc;
        end else begin
          imem_valid_i = 1'b0;
          imem_data_i  = 16'($urandom);
          wait_left--;
        end
      end
      @(posedge clk);
      #1;
      z_flag_i = env_z;
      if (acc) exp_exec = 1'b1;
    end
    check_eq("budget", 32'(cyc >= 3000), 32'd0);
  endtask

  task automatic check_regs();
    for (int i = 0; i < 4; i++) check_eq("regfile", 32'(env_rf[i]), 32'(m_rf[i]));
    check_eq("zflag", 32'(env_z), 32'(m_z));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset_n_i = 1'b0; imem_valid_i = 1'b0; imem_data_i = 16'h0000;
    z_flag_i = 1'b0; env_z = 1'b0; m_z = 1'b0;
    restart_model();
    init_regs();

    // LDI r1,3; LDI r2,0xFD; ADD r3,r1,r2 (0x0100, Z=0); JZ 0x10 not taken
    clear_mem();
    mem[0] = 16'h2403; mem[1] = 16'h28FD; mem[2] = 16'h1D80; mem[3] = 16'h4010;
    mem[4] = 16'hF000; mem[8'h10] = 16'hF000;
    do_reset();
    run_prog(100, 0);
    check_eq("p1_r3", 32'(env_rf[3]), 32'h0100);
    check_eq("p1_pc", 32'(pc_o), 32'h04);

    // zero sum sets Z so JZ is taken
    mem[0] = 16'h2400; mem[1] = 16'h2800;
    do_reset();
    run_prog(100, 0);
    check_eq("p1b_pc", 32'(pc_o), 32'h10);
    check_eq("p1b_z", 32'(z_flag_i), 32'd1);

    // JZ not taken, JNZ taken, 3-cycle memory latency
    clear_mem();
    mem[0] = 16'h2401; mem[1] = 16'h1940; mem[2] = 16'h4020; mem[3] = 16'h5030;
    mem[4] = 16'hF000; mem[8'h20] = 16'hF000; mem[8'h30] = 16'hF000;
    do_reset();
    run_prog(100, 3);
    check_eq("p2_pc", 32'(pc_o), 32'h30);
    check_eq("p2_r2", 32'(env_rf[2]), 32'h0002);

    // JMP 0xFF then NOP at 0xFF wraps to 0x00
    clear_mem();
    mem[0] = 16'h30FF;
    do_reset();
    run_prog(2, 0);
    @(negedge clk);
    check_eq("wrap_addr", 32'(imem_addr_o), 32'h00);
    check_eq("wrap_req", 32'(imem_req_o), 32'd1);

    // HALT at 0x05, then reset in the middle of a fetch
    clear_mem();
    mem[0] = 16'h2401; mem[2] = 16'h1940; mem[5] = 16'hF000;
    do_reset();
    run_prog(100, -1);
    check_eq("halt_at", 32'(pc_o), 32'h05);
    do_reset();
    imem_valid_i = 1'b0;
    @(negedge clk);
    check_eq("mid_req_hi", 32'(imem_req_o), 32'd1);
    #2 reset_n_i = 1'b0;
    #1;
    check_eq("mid_req_drop", 32'(imem_req_o), 32'd0);
    check_eq("mid_pc", 32'(pc_o), 32'h00);
    @(negedge clk);
    reset_n_i = 1'b1;
    restart_model();
    run_prog(100, 2);
    check_eq("restart_halt", 32'(pc_o), 32'h05);

    // illegal opcode 0x7 at 0x02
    clear_mem();
    mem[2] = 16'h7000; mem[3] = 16'hF000;
    do_reset();
    run_prog(100, 0);
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    check_eq("ill_pc", 32'(pc_o), 32'h02);
    check_eq("ill_flag", 32'(illegal_o), 32'd1);
`else
    check_eq("ill_pc", 32'(pc_o), 32'h03);
    check_eq("ill_flag", 32'(illegal_o), 32'd0);
`endif
    check_eq("ill_halted", 32'(halted_o), 32'd1);
    check_regs();

    // random programs, mostly legal opcodes with random fields and targets
    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < 256; a++) begin
        int r;
        logic [3:0] opc;
        r = int'($urandom_range(0, 19));
        if (r < 6 || r == 19)  opc = 4'h1;
        else if (r < 11)       opc = 4'h2;
        else if (r < 13)       opc = 4'h4;
        else if (r < 15)       opc = 4'h5;
        else if (r == 15)      opc = 4'h3;
        else if (r == 16)      opc = 4'h0;
        else if (r == 17)      opc = 4'(6 + $urandom_range(0, 8));
        else                   opc = 4'hF;
        mem[a] = {opc, 12'($urandom)};
      end
      init_regs();
      do_reset();
      run_prog(60, (t % 3 == 0) ? 1 : -1);
      check_regs();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
